// File: rtl/pipe_stage_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_elastic: valid/ready pipeline register with flush, bubble     |
// | gating and stall counter; define PIPE_STAGE_SKID_EN for the skid buffer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stage_elastic #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occ,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic                  main_v_q, main_v_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v_q & out_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  // A bubble must never present write enables downstream.
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                  in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign occ      = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (in_fire) begin
        main_v_d    = 1'b1;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end
    end else if (!skid_v_q) begin
      if (out_fire) begin
        if (in_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
        skid_ctrl_d = in_ctrl;
      end
    end else if (out_fire) begin
      main_data_d = skid_data_q;
      main_ctrl_d = skid_ctrl_q;
      skid_v_d    = 1'b0;
    end
    // Ready is the registered image of next-cycle skid emptiness.
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  logic run_q;

  // run_q holds in_ready low until the first edge after reset release.
  assign in_ready = run_q & (out_ready | !main_v_q);
  assign occ      = {1'b0, main_v_q};

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    if (flush) begin
      main_v_d = 1'b0;
    end else if (in_fire) begin
      main_v_d    = 1'b1;
      main_data_d = in_data;
      main_ctrl_d = in_ctrl;
    end else if (out_fire) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register for the pipelined RV32 core. It replaces the bare enable-gated flop stage between pipeline phases (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready stage. The stage carries a data bundle and a control bundle. It supports per-stage backpressure, synchronous flush for branch squash, bubble gating of control bits, and an optional skid buffer that keeps throughput at 1/cycle with a registered ready. One instance sits at each phase boundary.

## Interface
Parameters:
- DATA_WIDTH, 64: width of the data bundle (PC, operands, immediates, rd).
- CTRL_WIDTH, 11: width of the control bundle (write enables, ALU/dbus selects).
- CNT_WIDTH, 16: width of the saturating stall counter.

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_WIDTH  upstream data bundle.
- in_ctrl  in  CTRL_WIDTH  upstream control bundle.
- flush  in  1  squash all held beats and any incoming beat.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_WIDTH  held data bundle.
- out_ctrl  out  CTRL_WIDTH  held control bundle, forced to 0 when out_valid=0.
- occ  out  2  occupancy: 0, 1, or 2 (2 only with skid).
- stall_cnt  out  CNT_WIDTH  cycles with in_valid=1 and in_ready=0, saturating.

## Operation
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- Storage:
  - main register {main_v, main_d, main_c} drives out_*.
  - skid register {skid_v, skid_d, skid_c} exists only with skid enabled.
- States: EMPTY (main_v=0), BUSY (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1).
- EMPTY:
  - in_fire -> BUSY, main<=in.
- BUSY:
  - in_fire & out_fire -> BUSY, main<=in.
  - in_fire & !out_ready -> FULL, skid<=in.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL:
  - out_fire -> BUSY, main<=skid.
  - Otherwise hold.
  - in_ready=0 throughout.
- in_ready = !skid_v. It is a registered value with no combinational path from out_ready.
- Flush:
  - flush=1 at an edge -> EMPTY; main_v and skid_v cleared.
  - Flush overrides every other transition.
  - An in_fire in the flush cycle is completed from upstream's view, and the beat is discarded.
  - main_d and skid_d contents are don't-care after flush.
- Bubble gating: out_ctrl = main_v ? main_c : 0, so a bubble never asserts write enables downstream. out_data is not gated.
- occ = main_v + skid_v.
- stall_cnt:
  - Increments on every cycle with in_valid & !in_ready.
  - Saturates at 2^CNT_WIDTH-1.
  - Flush does not clear it.

## Timing
- Latency in->out: 1 cycle. A beat captured at edge N is visible on out_* after edge N.
- Throughput: 1 beat/cycle with out_ready held high.
- in_ready recovers 1 cycle after the FULL->BUSY drain.
- Reset (rst=0, async), all outputs forced:
  - in_ready=0.
  - out_valid=0, out_data=0, out_ctrl=0.
  - occ=0, stall_cnt=0.
- After reset: in_ready=1 from the first edge following rst deassertion.
- Reset mid-operation discards all held beats immediately, without waiting for a clock.
- Upstream rule: in_data/in_ctrl must remain stable while in_valid=1 and in_ready=0.
- Downstream rule: out_* remain stable while out_valid=1 and out_ready=0, with no flush.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Skid register is present.
  - FULL state reachable.
  - in_ready registered as above.
- PIPE_STAGE_SKID_EN undefined:
  - No skid register; FULL is unreachable and occ ≤ 1.
  - in_ready = out_ready | !main_v (combinational).
  - BUSY & in_fire & out_fire -> BUSY; BUSY & out_fire & !in_fire -> EMPTY.
  - Flush, gating, and the counter are unchanged.

## Test plan
- Reset, then stream 8 beats of data=i, ctrl=0x7FF with out_ready=1 -> 8 consecutive beats out, each 1 cycle later; occ ≤ 1; stall_cnt=0.
- BUSY with data=0xA, drive data=0xB while out_ready=0 (skid on) -> occ=2, in_ready=0. Then out_ready=1 -> out 0xA, then 0xB; in_ready returns 1 the cycle after 0xA drains.
- FULL, hold in_valid=1 for 5 cycles with out_ready=0 -> stall_cnt=5. With CNT_WIDTH=2 and 6 stall cycles -> stall_cnt=3.
- FULL, assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occ=0; the flushed input beat never appears on out_*.
- Drop rst to 0 mid-stream between edges -> out_valid=0, out_ctrl=0, in_ready=0 without a clock edge.
- Skid off: out_ready=0 while BUSY -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> pass-through at 1 beat/cycle.
